// File: rtl/mips_alu_pkg.sv
// Shared encodings for the MIPS ALU issue stage: ALU function codes,
// opcode/funct values and the decoded bundle layout.
package mips_alu_pkg;

   // ALU function codes; bits [5:4] select the unit
   localparam logic [5:0] FUN_ADD    = 6'b000000;
   localparam logic [5:0] FUN_SUB    = 6'b000001;
   localparam logic [5:0] FUN_AND    = 6'b011000;
   localparam logic [5:0] FUN_OR     = 6'b011110;
   localparam logic [5:0] FUN_XOR    = 6'b010110;
   localparam logic [5:0] FUN_NOR    = 6'b010001;
   localparam logic [5:0] FUN_PASS_A = 6'b011010;
   localparam logic [5:0] FUN_SLL    = 6'b100000;
   localparam logic [5:0] FUN_SRL    = 6'b100001;
   localparam logic [5:0] FUN_SRA    = 6'b100011;
   localparam logic [5:0] FUN_EQ     = 6'b110011;
   localparam logic [5:0] FUN_NEQ    = 6'b110001;
   localparam logic [5:0] FUN_LT     = 6'b110101;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   localparam int BUNDLE_W = 6 + 32 + 32 + 1 + 1;

   typedef struct packed {
      logic [5:0]  fun;
      logic [31:0] a;
      logic [31:0] b;
      logic        sign;
      logic        illegal;
   } alu_bundle_t;

   function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

   function automatic logic [31:0] zero_ext16(input logic [15:0] imm);
      return {16'h0000, imm};
   endfunction

endpackage

// File: rtl/alu_fun_decode.sv
// Combinational decode of a MIPS instruction word into the ALU function
// code, operands and sign/illegal flags.
module alu_fun_decode
   import mips_alu_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic [5:0]  alu_fun,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic        alu_sign,
   output logic        illegal
);

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [15:0] imm;
   logic        unused_fields;

   assign opcode = instr[31:26];
   assign funct  = instr[5:0];
   assign shamt  = instr[10:6];
   assign imm    = instr[15:0];
   // Register indices are resolved upstream; only their data arrives here.
   assign unused_fields = ^instr[25:21];

   always_comb begin
      alu_fun  = FUN_ADD;
      alu_a    = 32'h0;
      alu_b    = 32'h0;
      alu_sign = 1'b0;
      illegal  = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            alu_a = rs_data;
            alu_b = rt_data;
            case (funct)
               FN_ADD:  begin alu_fun = FUN_ADD; alu_sign = 1'b1; end
               FN_ADDU: alu_fun = FUN_ADD;
               FN_SUB:  begin alu_fun = FUN_SUB; alu_sign = 1'b1; end
               FN_SUBU: alu_fun = FUN_SUB;
               FN_AND:  alu_fun = FUN_AND;
               FN_OR:   alu_fun = FUN_OR;
               FN_XOR:  alu_fun = FUN_XOR;
               FN_NOR:  alu_fun = FUN_NOR;
               FN_SLT:  begin alu_fun = FUN_LT; alu_sign = 1'b1; end
               FN_SLTU: alu_fun = FUN_LT;
               FN_SLL:  begin alu_fun = FUN_SLL; alu_a = {27'b0, shamt}; end
               FN_SRL:  begin alu_fun = FUN_SRL; alu_a = {27'b0, shamt}; end
               FN_SRA:  begin alu_fun = FUN_SRA; alu_a = {27'b0, shamt}; end
               default: begin
                  illegal = 1'b1;
                  alu_a   = 32'h0;
                  alu_b   = 32'h0;
               end
            endcase
         end
         OP_ADDI: begin
            alu_a = rs_data; alu_b = sign_ext16(imm); alu_sign = 1'b1;
         end
         OP_ADDIU, OP_LW, OP_SW: begin
            alu_a = rs_data; alu_b = sign_ext16(imm);
         end
         OP_SLTI: begin
            alu_fun = FUN_LT; alu_a = rs_data; alu_b = sign_ext16(imm); alu_sign = 1'b1;
         end
         OP_SLTIU: begin
            alu_fun = FUN_LT; alu_a = rs_data; alu_b = sign_ext16(imm);
         end
         OP_ANDI: begin
            alu_fun = FUN_AND; alu_a = rs_data; alu_b = zero_ext16(imm);
         end
         OP_ORI: begin
            alu_fun = FUN_OR; alu_a = rs_data; alu_b = zero_ext16(imm);
         end
         OP_XORI: begin
            alu_fun = FUN_XOR; alu_a = rs_data; alu_b = zero_ext16(imm);
         end
         OP_LUI: begin
            alu_fun = FUN_PASS_A; alu_a = {imm, 16'h0000};
         end
         OP_BEQ: begin
            alu_fun = FUN_EQ; alu_a = rs_data; alu_b = rt_data; alu_sign = 1'b1;
         end
         OP_BNE: begin
            alu_fun = FUN_NEQ; alu_a = rs_data; alu_b = rt_data; alu_sign = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: decodes the instruction and holds the ALU bundle in a
// two-entry skid buffer (main drives outputs, skid absorbs one stall).
module alu_issue_stage
   import mips_alu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [5:0]  alu_fun,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic        alu_sign,
   output logic        illegal
);

   alu_bundle_t dec_bundle;
   alu_bundle_t main_reg, main_next;
   alu_bundle_t skid_reg, skid_next;
   logic        main_valid_reg, main_valid_next;
   logic        skid_valid_reg, skid_valid_next;
   logic        in_ready_reg, in_ready_next;
   logic        accept, pop, main_free;

   alu_fun_decode u_decode (
      .instr    (instr),
      .rs_data  (rs_data),
      .rt_data  (rt_data),
      .alu_fun  (dec_bundle.fun),
      .alu_a    (dec_bundle.a),
      .alu_b    (dec_bundle.b),
      .alu_sign (dec_bundle.sign),
      .illegal  (dec_bundle.illegal)
   );

   // An instruction offered during a flush is part of the squashed path.
   assign accept    = in_valid && in_ready_reg && !flush;
   assign pop       = main_valid_reg && out_ready;
   assign main_free = !main_valid_reg || pop;

   always_comb begin
      main_valid_next = main_valid_reg;
      skid_valid_next = skid_valid_reg;
      main_next       = main_reg;
      skid_next       = skid_reg;
      if (flush) begin
         main_valid_next = 1'b0;
         skid_valid_next = 1'b0;
      end else if (main_free) begin
         if (skid_valid_reg) begin
            main_next       = skid_reg;
            main_valid_next = 1'b1;
            skid_valid_next = accept;
            if (accept) skid_next = dec_bundle;
         end else begin
            main_valid_next = accept;
            if (accept) main_next = dec_bundle;
         end
      end else if (accept) begin
         skid_valid_next = 1'b1;
         skid_next       = dec_bundle;
      end
      in_ready_next = !skid_valid_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         main_reg       <= '0;
         skid_reg       <= '0;
         main_valid_reg <= 1'b0;
         skid_valid_reg <= 1'b0;
         in_ready_reg   <= 1'b1;
      end else begin
         main_reg       <= main_next;
         skid_reg       <= skid_next;
         main_valid_reg <= main_valid_next;
         skid_valid_reg <= skid_valid_next;
         in_ready_reg   <= in_ready_next;
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = main_valid_reg;
   assign alu_fun   = main_reg.fun;
   assign alu_a     = main_reg.a;
   assign alu_b     = main_reg.b;
   assign alu_sign  = main_reg.sign;
   assign illegal   = main_reg.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: expected bundles are queued at accept
// time and compared in order when the stage hands a bundle to the ALU.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] instr, rs_data, rt_data, alu_a, alu_b;
   logic [5:0]  alu_fun;
   logic        alu_sign, illegal;
   logic [71:0] obs;
   logic [71:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cycle = 0;
   int          t0;

   alu_issue_stage dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_fun(alu_fun), .alu_a(alu_a), .alu_b(alu_b),
      .alu_sign(alu_sign), .illegal(illegal)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;
   assign obs = {alu_fun, alu_a, alu_b, alu_sign, illegal};

   function automatic logic [71:0] mk(input logic [5:0] f, input logic [31:0] a,
                                      input logic [31:0] b, input logic s, input logic il);
      return {f, a, b, s, il};
   endfunction

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Output monitor: every handed-off bundle must match the oldest expectation.
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out", 72'(exp_q.size()), 72'd1);
         end else begin
            logic [71:0] e;
            e = exp_q.pop_front();
            $display("pop fun=%b a=%h b=%h sign=%b illegal=%b", alu_fun, alu_a, alu_b, alu_sign, illegal);
            check("pop_bundle", obs, e);
         end
      end
   end

   task automatic send(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [71:0] e);
      bit done;
      done = 1'b0;
      instr = i; rs_data = rs; rt_data = rt; in_valid = 1'b1;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(e);
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("accept_in_time", 72'(done), 72'd1);
   endtask

   task automatic drain();
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
         @(posedge clk); #1;
      end
      check("queue_drained", 72'(exp_q.size()), 72'd0);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      instr = 32'h0; rs_data = 32'h0; rt_data = 32'h0;
      repeat (2) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("reset_out_valid", 72'(out_valid), 72'd0);
      check("reset_in_ready", 72'(in_ready), 72'd1);
      check("reset_bundle", obs, 72'd0);
      @(posedge clk); #1;

      // Single transfers, latency of one cycle
      out_ready = 1'b1;
      send(32'h3422_8001, 32'h0000_00F0, 32'h0, mk(6'b011110, 32'h0000_00F0, 32'h0000_8001, 1'b0, 1'b0));
      check("latency_out_valid", 72'(out_valid), 72'd1);
      send(32'h0002_1903, 32'h0000_1234, 32'h8000_0000, mk(6'b100011, 32'd4, 32'h8000_0000, 1'b0, 1'b0));
      send(32'h2001_FFFF, 32'h0000_0005, 32'h0, mk(6'b000000, 32'h5, 32'hFFFF_FFFF, 1'b1, 1'b0));
      send(32'h3C01_1234, 32'h0000_DEAD, 32'h0, mk(6'b011010, 32'h1234_0000, 32'h0, 1'b0, 1'b0));
      send(32'h0022_1822, 32'h0000_0010, 32'h3, mk(6'b000001, 32'h10, 32'h3, 1'b1, 1'b0));
      send(32'h1022_0004, 32'hAAAA_0001, 32'hAAAA_0001, mk(6'b110011, 32'hAAAA_0001, 32'hAAAA_0001, 1'b1, 1'b0));
      send(32'h2C22_8000, 32'h0000_0007, 32'h0, mk(6'b110101, 32'h7, 32'hFFFF_8000, 1'b0, 1'b0));
      send(32'h0022_1827, 32'h0F0F_0000, 32'h00FF_00FF, mk(6'b010001, 32'h0F0F_0000, 32'h00FF_00FF, 1'b0, 1'b0));
      send(32'hAC22_FFFC, 32'h0000_1000, 32'h9, mk(6'b000000, 32'h1000, 32'hFFFF_FFFC, 1'b0, 1'b0));
      send(32'h3022_F0F0, 32'h1234_5678, 32'h0, mk(6'b011000, 32'h1234_5678, 32'h0000_F0F0, 1'b0, 1'b0));
      send(32'hFC00_0000, 32'h0000_0055, 32'h66, mk(6'b000000, 32'h0, 32'h0, 1'b0, 1'b1));
      send(32'h0022_183F, 32'h0000_0055, 32'h66, mk(6'b000000, 32'h0, 32'h0, 1'b0, 1'b1));
      drain();

      // Back-pressure: two accepted while stalled, third waits
      out_ready = 1'b0;
      instr = 32'h0022_1820; rs_data = 32'h1; rt_data = 32'h2; in_valid = 1'b1;
      @(negedge clk);
      check("bp_ready_first", 72'(in_ready), 72'd1);
      exp_q.push_back(mk(6'b000000, 32'h1, 32'h2, 1'b1, 1'b0));
      @(posedge clk); #1;
      instr = 32'h0022_1825; rs_data = 32'h3; rt_data = 32'h4;
      @(negedge clk);
      check("bp_ready_second", 72'(in_ready), 72'd1);
      exp_q.push_back(mk(6'b011110, 32'h3, 32'h4, 1'b0, 1'b0));
      @(posedge clk); #1;
      instr = 32'h0022_1826; rs_data = 32'h5; rt_data = 32'h6;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("bp_ready_low", 72'(in_ready), 72'd0);
         check("bp_out_valid", 72'(out_valid), 72'd1);
         check("bp_stable", obs, mk(6'b000000, 32'h1, 32'h2, 1'b1, 1'b0));
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      send(32'h0022_1826, 32'h5, 32'h6, mk(6'b010110, 32'h5, 32'h6, 1'b0, 1'b0));
      drain();

      // Flush while full, with an offer in the flush cycle
      out_ready = 1'b0;
      send(32'h3422_0001, 32'h11, 32'h0, mk(6'b011110, 32'h11, 32'h1, 1'b0, 1'b0));
      send(32'h3422_0002, 32'h22, 32'h0, mk(6'b011110, 32'h22, 32'h2, 1'b0, 1'b0));
      instr = 32'h3422_0003; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("flush_out_valid", 72'(out_valid), 72'd0);
      check("flush_in_ready", 72'(in_ready), 72'd1);
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("flush_no_output", 72'(out_valid), 72'd0);
      end
      @(posedge clk); #1;

      // Flush with a pop in the same cycle; the offered instruction is dropped
      out_ready = 1'b0;
      send(32'h3822_00AA, 32'h0F, 32'h0, mk(6'b010110, 32'h0F, 32'hAA, 1'b0, 1'b0));
      out_ready = 1'b1; flush = 1'b1; instr = 32'h3822_00BB; in_valid = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      check("flush_pop_completed", 72'(exp_q.size()), 72'd0);
      repeat (3) begin
         @(negedge clk);
         check("flush_drop", 72'(out_valid), 72'd0);
      end
      @(posedge clk); #1;

      // Reset during a stall
      out_ready = 1'b0;
      send(32'h2001_0001, 32'h1, 32'h0, mk(6'b000000, 32'h1, 32'h1, 1'b1, 1'b0));
      send(32'h2001_0002, 32'h2, 32'h0, mk(6'b000000, 32'h2, 32'h2, 1'b1, 1'b0));
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("rst_stall_valid", 72'(out_valid), 72'd0);
      check("rst_stall_ready", 72'(in_ready), 72'd1);
      check("rst_stall_bundle", obs, 72'd0);
      out_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("rst_stall_quiet", 72'(out_valid), 72'd0);
      end
      @(posedge clk); #1;

      // Full throughput with out_ready held high
      t0 = cycle;
      for (int k = 0; k < 4; k++)
         send(32'h3422_0000 | 32'(k), 32'(k * 16), 32'h0,
              mk(6'b011110, 32'(k * 16), 32'(k), 1'b0, 1'b0));
      check("throughput_cycles", 72'(cycle - t0), 72'd4);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
